raster_sequencer: RTL and testbench

- Sequences the pixel datapath of the demo: generates the pixel-enable strobe, the x/y raster position, blanking, sync and frame-boundary signals.
- Owns the frame counter: free-running, paused, or single-stepped via `advance_frame`.
- Sits inside `demo_top`, between the `clk`/`reset` domain and the color/audio generators.
- Sync outputs are active-high; the pad wrapper applies any inversion.

---
 rtl/raster_sequencer.sv | 137 +++++++++++++
 tb/tb_raster_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_sequencer.sv
// raster_sequencer: pixel strobe, x/y raster position, blanking/sync decode
// and a pausable, single-steppable frame counter.
// Optional feature macro RASTER_LINE_MATCH_EN adds match_line/line_match.
module raster_sequencer #(
    parameter int CLK_DIV    = 1,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FULL_FPS   = 1,
    parameter int FRAME_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pause,
    input  logic                  advance_frame,
`ifdef RASTER_LINE_MATCH_EN
    input  logic [9:0]            match_line,
    output logic                  line_match,
`endif
    output logic                  enable,
    output logic [9:0]            x,
    output logic [9:0]            y,
    output logic                  active,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  new_frame,
    output logic [FRAME_BITS-1:0] frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef enum logic {ST_RUN = 1'b0, ST_PAUSED = 1'b1} state_t;

    logic [3:0]            r_div;
    logic                  r_en;
    logic [9:0]            r_x;
    logic [9:0]            r_y;
    logic [FRAME_BITS-1:0] r_frame;
    state_t                r_state;
    logic                  r_adv_q;
    logic                  r_adv_q2;
    logic                  r_pend;
    logic                  r_tog;

    logic                  w_div_last;
    logic                  w_x_last;
    logic                  w_y_last;
    logic [9:0]            w_y_next;
    logic                  w_adv_edge;
    logic                  w_gate;
    logic                  w_step;

    assign w_div_last = (r_div == 4'(CLK_DIV - 1));
    assign w_x_last   = (r_x == 10'(H_TOTAL - 1));
    assign w_y_last   = (r_y == 10'(V_TOTAL - 1));
    // Line that becomes current when x wraps; never reaches V_TOTAL.
    assign w_y_next   = w_y_last ? 10'd0 : r_y + 10'd1;

    // Clock divider; enable is registered so it lands one cycle after the last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= 4'd0;
            r_en  <= 1'b0;
        end else begin
            r_en  <= w_div_last;
            r_div <= w_div_last ? 4'd0 : r_div + 4'd1;
        end
    end

    // Raster position, advanced once per pixel strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= 10'd0;
            r_y <= 10'd0;
        end else if (r_en) begin
            if (w_x_last) begin
                r_x <= 10'd0;
                r_y <= w_y_next;
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    // Decodes are straight off the x/y registers so they track x/y with no lag.
    assign active    = (r_x < 10'(H_ACTIVE)) && (r_y < 10'(V_ACTIVE));
    assign hsync     = (r_x >= 10'(H_ACTIVE + H_FP)) && (r_x < 10'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync     = (r_y >= 10'(V_ACTIVE + V_FP)) && (r_y < 10'(V_ACTIVE + V_FP + V_SYNC));
    assign new_frame = r_en && w_x_last && w_y_last;

`ifdef RASTER_LINE_MATCH_EN
    // Fires on the strobe that starts line match_line; out-of-range targets never match.
    assign line_match = r_en && w_x_last && (w_y_next == match_line);
`endif

    assign w_adv_edge = r_adv_q & ~r_adv_q2;
    // At half rate the gate opens on every second frame boundary.
    assign w_gate     = (FULL_FPS != 0) ? 1'b1 : r_tog;
    assign w_step     = new_frame && w_gate && ((r_state == ST_RUN) || r_pend);

    // Frame stepping FSM: run/pause tracking, step request capture and the frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_adv_q  <= 1'b0;
            r_adv_q2 <= 1'b0;
            r_pend   <= 1'b0;
            r_tog    <= 1'b0;
            r_frame  <= '0;
        end else begin
            r_state  <= pause ? ST_PAUSED : ST_RUN;
            r_adv_q  <= advance_frame;
            r_adv_q2 <= r_adv_q;
            if (new_frame)
                r_tog <= ~r_tog;
            if (w_step)
                r_frame <= r_frame + 1'b1;
            // A request landing on the consuming boundary survives to the next one.
            if (w_adv_edge && (r_state == ST_PAUSED))
                r_pend <= 1'b1;
            else if (w_step)
                r_pend <= 1'b0;
        end
    end

    assign enable = r_en;
    assign x      = r_x;
    assign y      = r_y;
    assign frame  = r_frame;

endmodule

// File: tb/tb_raster_sequencer.sv
// Bench for raster_sequencer: three small-raster instances (div 1, div 3 with
// 2-bit frame, half rate) against an arithmetic reference model, plus tables
// and hand sequences for the frame stepping corners.
module tb_raster_sequencer;
    localparam int HA = 8, HF = 2, HS = 3, HB = 1;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = 14, VT = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pause = 1'b0;
    logic adv = 1'b0;
    logic [9:0] ml = 10'd0;

    always #5 clk = ~clk;

    logic en_o[3], act_o[3], hs_o[3], vs_o[3], nf_o[3], lm_o[3];
    logic [9:0] x_o[3], y_o[3];
    logic [15:0] fa, fc;
    logic [1:0] fb;
    logic [15:0] fr_o[3];
    assign fr_o[0] = fa;
    assign fr_o[1] = {14'd0, fb};
    assign fr_o[2] = fc;
`ifndef RASTER_LINE_MATCH_EN
    assign lm_o[0] = 1'b0;
    assign lm_o[1] = 1'b0;
    assign lm_o[2] = 1'b0;
`endif

    raster_sequencer #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .FULL_FPS(1), .FRAME_BITS(16)) u_a (
        .clk(clk), .reset(reset), .pause(pause), .advance_frame(adv),
`ifdef RASTER_LINE_MATCH_EN
        .match_line(ml), .line_match(lm_o[0]),
`endif
        .enable(en_o[0]), .x(x_o[0]), .y(y_o[0]), .active(act_o[0]), .hsync(hs_o[0]),
        .vsync(vs_o[0]), .new_frame(nf_o[0]), .frame(fa));

    raster_sequencer #(.CLK_DIV(3), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .FULL_FPS(1), .FRAME_BITS(2)) u_b (
        .clk(clk), .reset(reset), .pause(pause), .advance_frame(adv),
`ifdef RASTER_LINE_MATCH_EN
        .match_line(ml), .line_match(lm_o[1]),
`endif
        .enable(en_o[1]), .x(x_o[1]), .y(y_o[1]), .active(act_o[1]), .hsync(hs_o[1]),
        .vsync(vs_o[1]), .new_frame(nf_o[1]), .frame(fb));

    raster_sequencer #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .FULL_FPS(0), .FRAME_BITS(16)) u_c (
        .clk(clk), .reset(reset), .pause(pause), .advance_frame(adv),
`ifdef RASTER_LINE_MATCH_EN
        .match_line(ml), .line_match(lm_o[2]),
`endif
        .enable(en_o[2]), .x(x_o[2]), .y(y_o[2]), .active(act_o[2]), .hsync(hs_o[2]),
        .vsync(vs_o[2]), .new_frame(nf_o[2]), .frame(fc));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [41:0] pk(input logic en, input logic [9:0] xx, input logic [9:0] yy,
        input logic act, input logic hs, input logic vs, input logic nf, input logic [15:0] fr,
        input logic lm);
        return {en, xx, yy, act, hs, vs, nf, fr, lm};
    endfunction

    function automatic logic [41:0] dut_pk(input int i);
        return pk(en_o[i], x_o[i], y_o[i], act_o[i], hs_o[i], vs_o[i], nf_o[i], fr_o[i], lm_o[i]);
    endfunction

    // Reference model: position follows from the count of edges since reset.
    int          mn[3];
    logic [15:0] mf[3];
    bit          mpend[3], mtog[3], mpsd[3], maq[3], maq2[3];
    int          DV[3]  = '{1, 3, 1};
    bit          FFV[3] = '{1'b1, 1'b1, 1'b0};
    logic [15:0] FMK[3] = '{16'hFFFF, 16'h0003, 16'hFFFF};

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mn[i] = 0; mf[i] = 16'd0; mpend[i] = 0; mtog[i] = 0;
            mpsd[i] = 0; maq[i] = 0; maq2[i] = 0;
        end
    endtask

    task automatic decode(input int i, output logic [41:0] v, output bit nf);
        int p, xx, yy;
        bit en, lm;
        en = (mn[i] > 0) && (mn[i] % DV[i] == 0);
        p  = (mn[i] == 0) ? 0 : (mn[i] - 1) / DV[i];
        xx = p % HT;
        yy = (p / HT) % VT;
        nf = en && (xx == HT - 1) && (yy == VT - 1);
`ifdef RASTER_LINE_MATCH_EN
        lm = en && (xx == HT - 1) && (((yy + 1) % VT) == int'(ml));
`else
        lm = 1'b0;
`endif
        v = pk(en, 10'(xx), 10'(yy), (xx < HA) && (yy < VA),
               (xx >= HA + HF) && (xx < HA + HF + HS),
               (yy >= VA + VF) && (yy < VA + VF + VS), nf, mf[i], lm);
    endtask

    task automatic model_edge(input int i);
        logic [41:0] v;
        bit nf, gate, stepped;
        decode(i, v, nf);
        stepped = 0;
        if (nf) begin
            gate = FFV[i] ? 1'b1 : mtog[i];
            if (gate && (!mpsd[i] || mpend[i])) begin
                mf[i] = (mf[i] + 16'd1) & FMK[i];
                stepped = 1;
            end
            mtog[i] = ~mtog[i];
        end
        if (maq[i] && !maq2[i] && mpsd[i]) mpend[i] = 1;
        else if (stepped) mpend[i] = 0;
        mpsd[i] = pause;
        maq2[i] = maq[i];
        maq[i]  = adv;
        mn[i]++;
    endtask

    task automatic model_cmp();
        logic [41:0] v;
        bit nf;
        for (int i = 0; i < 3; i++) begin
            decode(i, v, nf);
            chk($sformatf("model_u%0d_n%0d", i, mn[i]), 64'(dut_pk(i)), 64'(v));
        end
    endtask

    task automatic tick();
        for (int i = 0; i < 3; i++) model_edge(i);
        @(posedge clk);
        @(negedge clk);
        model_cmp();
    endtask

    task automatic run_to(input int n);
        while (mn[0] < n) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Asynchronous reset: outputs must clear without any clock edge.
    task automatic mid_reset();
        reset = 1'b1;
        #1;
        chk("async_reset_a", 64'(dut_pk(0)), 64'(pk(0, 10'd0, 10'd0, 1, 0, 0, 0, 16'd0, 0)));
        model_reset();
        model_cmp();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        int n;
        logic en; int xx; int yy; logic act, hs, vs, nf; int fr;
    } vec_t;
    vec_t tbl[16];

    int cnt, at, both;
    logic [1:0] b_en_exp[6];
    logic [1:0] b_x_exp[6];

    initial begin
        tbl[0]  = '{0,   1'b0, 0,  0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1,   1'b1, 0,  0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{8,   1'b1, 7,  0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{9,   1'b1, 8,  0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[4]  = '{10,  1'b1, 9,  0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[5]  = '{11,  1'b1, 10, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[6]  = '{13,  1'b1, 12, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[7]  = '{14,  1'b1, 13, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[8]  = '{15,  1'b1, 0,  1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[9]  = '{57,  1'b1, 0,  4, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[10] = '{71,  1'b1, 0,  5, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[11] = '{97,  1'b1, 12, 6, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[12] = '{99,  1'b1, 0,  7, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[13] = '{111, 1'b1, 12, 7, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[14] = '{112, 1'b1, 13, 7, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[15] = '{113, 1'b1, 0,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        b_en_exp = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
        b_x_exp  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};

        // Raster decode table on the divide-by-1 instance.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            run_to(tbl[k].n);
            chk($sformatf("table_n%0d", tbl[k].n), 64'(dut_pk(0)),
                64'(pk(tbl[k].en, 10'(tbl[k].xx), 10'(tbl[k].yy), tbl[k].act, tbl[k].hs,
                       tbl[k].vs, tbl[k].nf, 16'(tbl[k].fr), 1'b0) & ~42'd1));
        end

        // Divide-by-3 strobe pattern and x hold.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("div3_en_n%0d", k + 1), 64'(en_o[1]), 64'(b_en_exp[k]));
            chk($sformatf("div3_x_n%0d", k + 1), 64'(x_o[1]), 64'(b_x_exp[k]));
        end

        // Paused for three frames, then two requests collapse to one step.
        do_reset();
        pause = 1'b1;
        run_to(340);
        chk("paused_3_frames", 64'(fa), 64'd0);
        adv = 1'b1; tick(); tick();
        adv = 1'b0; tick(); tick();
        adv = 1'b1; tick(); tick();
        adv = 1'b0;
        run_to(448);
        chk("step_before_boundary", 64'(fa), 64'd0);
        tick();
        chk("step_applied", 64'(fa), 64'd1);
        chk("step_applied_half_rate", 64'(fc), 64'd1);
        run_to(562);
        chk("step_held", 64'(fa), 64'd1);
        // Request coinciding with new_frame waits one more frame.
        run_to(671);
        adv = 1'b1;
        tick();
        chk("coincide_nf_seen", 64'(nf_o[0]), 64'd1);
        tick();
        adv = 1'b0;
        chk("coincide_not_now", 64'(fa), 64'd1);
        run_to(785);
        chk("coincide_next_frame", 64'(fa), 64'd2);
        run_to(897);
        chk("coincide_held", 64'(fa), 64'd2);

        // Free-running: full rate, half rate, 2-bit counter.
        do_reset();
        pause = 1'b0;
        run_to(673);
        chk("run6_full", 64'(fa), 64'd6);
        chk("run6_half", 64'(fc), 64'd3);
        chk("run2_div3", 64'(fb), 64'd2);
        run_to(706);
        chk("pre_reset_pos", 64'({x_o[0], y_o[0]}), 64'({10'd5, 10'd2}));
        mid_reset();

`ifdef RASTER_LINE_MATCH_EN
        do_reset();
        ml = 10'd3; cnt = 0; at = -1;
        repeat (113) begin
            tick();
            if (lm_o[0]) begin cnt++; at = mn[0]; end
        end
        chk("lm3_count", 64'(cnt), 64'd1);
        chk("lm3_at", 64'(at), 64'd42);
        ml = 10'd0; cnt = 0; both = 0;
        repeat (112) begin
            tick();
            if (lm_o[0]) cnt++;
            if (lm_o[0] && nf_o[0]) both++;
        end
        chk("lm0_count", 64'(cnt), 64'd1);
        chk("lm0_with_nf", 64'(both), 64'd1);
        ml = 10'd9; cnt = 0;
        repeat (112) begin
            tick();
            if (lm_o[0]) cnt++;
        end
        chk("lm9_never", 64'(cnt), 64'd0);
`endif

        // Randomized run against the model.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 199) == 0) pause = ~pause;
            if ($urandom_range(0, 19) == 0) adv = ~adv;
            if ($urandom_range(0, 499) == 0) ml = 10'($urandom_range(0, 9));
            if ($urandom_range(0, 1999) == 0) mid_reset();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
